// File: rtl/rv32_pkg.sv
// Shared RV32 types: the datapath word, ALU operation select, and the
// per-requester ALU request bundle used by the shared-ALU arbiter.
package rv32_pkg;

    typedef logic [31:0] rv32_word;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_opsel_t;

    typedef struct packed {
        rv32_word   op1;
        rv32_word   op2;
        alu_opsel_t opsel;
    } alu_req_t;

    localparam int ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/rv32_int_alu.sv
// Combinational RV32 integer ALU; all arithmetic wraps modulo 2^32 and
// shift amounts use the low five bits of op2.
module rv32_int_alu
    import rv32_pkg::*;
(
    input  rv32_word   op1,
    input  rv32_word   op2,
    input  alu_opsel_t opsel,
    output rv32_word   result
);

    always_comb begin
        result = '0;
        case (opsel)
            ALU_ADD:  result = op1 + op2;
            ALU_SUB:  result = op1 - op2;
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_SLL:  result = op1 << op2[4:0];
            ALU_SRL:  result = op1 >> op2[4:0];
            ALU_SRA:  result = rv32_word'($signed(op1) >>> op2[4:0]);
            ALU_SLT:  result = {31'd0, $signed(op1) < $signed(op2)};
            ALU_SLTU: result = {31'd0, op1 < op2};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin picker: grants the first set req bit at or after
// ptr (wrapping). The pointer itself is owned by the instantiating module.
module rv32_rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        if (enable) begin
            // Scan from farthest to nearest so the candidate closest to ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                idx = (int'(ptr) + k) % N;
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    grant_idx  = IW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/rv32_alu_arbiter.sv
// Shares one rv32_int_alu between NUM_REQ requesters with round-robin grant
// and a single registered, id-tagged response. Optional: ALU_ARB_STATS_EN.
module rv32_alu_arbiter
    import rv32_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [31:0]        req_op1   [NUM_REQ],
    input  logic [31:0]        req_op2   [NUM_REQ],
    input  alu_opsel_t         req_opsel [NUM_REQ],
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_result
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]        grant_count [NUM_REQ]
`endif
);

    logic              rsp_valid_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    rv32_word          rsp_result_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   rr_ptr_next;

    logic              can_accept;
    logic              accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    alu_req_t          req_bus [NUM_REQ];
    alu_req_t          sel_req;
    rv32_word          alu_result;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_bus
        assign req_bus[gi] = '{op1: req_op1[gi], op2: req_op2[gi], opsel: req_opsel[gi]};
    end

    // Accepting while the head drains keeps one op per cycle with no bubble.
    assign can_accept = !rsp_valid_reg || rsp_ready;

    rv32_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .enable    (can_accept && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept    = |grant;
    assign req_ready = grant;
    assign sel_req   = req_bus[grant_idx];

    rv32_int_alu u_alu (
        .op1    (sel_req.op1),
        .op2    (sel_req.op2),
        .opsel  (sel_req.opsel),
        .result (alu_result)
    );

    assign rr_ptr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_result_reg <= '0;
            rr_ptr_reg     <= '0;
        end else if (accept) begin
            rsp_valid_reg  <= 1'b1;
            rsp_id_reg     <= grant_idx;
            rsp_result_reg <= alu_result;
            rr_ptr_reg     <= rr_ptr_next;
        end else if (rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;

`ifdef ALU_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
        logic [31:0] count_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                count_reg <= '0;
            end else if (grant[gi]) begin
                count_reg <= count_reg + 32'd1;
            end
        end

        assign grant_count[gi] = count_reg;
    end
`endif

endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// Directed bench for rv32_alu_arbiter (4 requesters); stats checks are
// compiled in when ALU_ARB_STATS_EN is defined.
module tb_rv32_alu_arbiter;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_op1   [4];
    logic [31:0] req_op2   [4];
    alu_opsel_t  req_opsel [4];
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] grant_count [4];
`endif

    int checks   = 0;
    int failures = 0;

    rv32_alu_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_opsel  (req_opsel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    always #5 clk = ~clk;

    // Every task starts and ends 1 time unit after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 4'b0000;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input alu_opsel_t op);
        req_op1[i]   = a;
        req_op2[i]   = b;
        req_opsel[i] = op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_rsp_valid c=%0d got=%b want=0", c, rsp_valid);
            end
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL reset_req_ready c=%0d got=%b want=0000", c, req_ready);
            end
            checks++;
            if (dut.rr_ptr_reg !== 2'd0) begin
                failures++;
                $display("FAIL reset_rr_ptr c=%0d got=%0d want=0", c, dut.rr_ptr_reg);
            end
            next_cycle();
        end
    endtask

    task automatic test_single_add();
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_req_ready got=%b want=0001", req_ready);
        end
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd12) begin
            failures++;
            $display("FAIL single_rsp got v=%b id=%0d r=%0d want v=1 id=0 r=12", rsp_valid, rsp_id, rsp_result);
        end
        $display("single: id=%0d result=%0d", rsp_id, rsp_result);
        next_cycle();
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got=%b want=0", rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 32'(i), 32'd100, ALU_ADD);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c < 5) begin
                checks++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    failures++;
                    $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            if (c > 0) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) || rsp_result !== 32'(100 + (c - 1) % 4)) begin
                    failures++;
                    $display("FAIL rr_rsp c=%0d got v=%b id=%0d r=%0d want v=1 id=%0d r=%0d",
                             c, rsp_valid, rsp_id, rsp_result, (c - 1) % 4, 100 + (c - 1) % 4);
                end
                $display("rr: id=%0d result=%0d", rsp_id, rsp_result);
            end
            next_cycle();
        end
        req_valid = 4'b0000;
        next_cycle();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(0, 32'd10, 32'd20, ALU_ADD);
        set_req(1, 32'd40, 32'd8, ALU_SUB);
        set_req(2, 32'h0000_00F0, 32'h0000_003C, ALU_AND);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_first_grant got=%b want=0001", req_ready);
        end
        next_cycle();
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold_ready c=%0d got=%b want=0000", c, req_ready);
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd30) begin
                failures++;
                $display("FAIL bp_hold_rsp c=%0d got v=%b id=%0d r=%0d want v=1 id=0 r=30", c, rsp_valid, rsp_id, rsp_result);
            end
            next_cycle();
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_release_grant got=%b want=0010", req_ready);
        end
        next_cycle();
        req_valid = 4'b0100;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'd32) begin
            failures++;
            $display("FAIL bp_rsp1 got v=%b id=%0d r=%0d want v=1 id=1 r=32", rsp_valid, rsp_id, rsp_result);
        end
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_grant2 got=%b want=0100", req_ready);
        end
        $display("bp: id=%0d result=%0d", rsp_id, rsp_result);
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 32'h30) begin
            failures++;
            $display("FAIL bp_rsp2 got v=%b id=%0d r=%h want v=1 id=2 r=30", rsp_valid, rsp_id, rsp_result);
        end
        next_cycle();
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got=%b want=0", rsp_valid);
        end
        next_cycle();
    endtask

    task automatic test_wrap_skip();
        do_reset();
        set_req(2, 32'hFFFF_FFFF, 32'd1, ALU_ADD);
        set_req(1, 32'd1, 32'd4, ALU_SLL);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_grant2 got=%b want=0100", req_ready);
        end
        next_cycle();
        req_valid = 4'b0010;
        #1;
        checks++;
        if (rsp_id !== 2'd2 || rsp_result !== 32'd0) begin
            failures++;
            $display("FAIL wrap_overflow got id=%0d r=%h want id=2 r=0", rsp_id, rsp_result);
        end
        checks++;
        if (dut.rr_ptr_reg !== 2'd3) begin
            failures++;
            $display("FAIL wrap_ptr3 got=%0d want=3", dut.rr_ptr_reg);
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL wrap_skip_grant got=%b want=0010", req_ready);
        end
        next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (rsp_id !== 2'd1 || rsp_result !== 32'd16 || dut.rr_ptr_reg !== 2'd2) begin
            failures++;
            $display("FAIL wrap_after got id=%0d r=%0d ptr=%0d want id=1 r=16 ptr=2", rsp_id, rsp_result, dut.rr_ptr_reg);
        end
        next_cycle();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || dut.rr_ptr_reg !== 2'd2) begin
            failures++;
            $display("FAIL wrap_idle got v=%b ptr=%0d want v=0 ptr=2", rsp_valid, dut.rr_ptr_reg);
        end
        next_cycle();
    endtask

    task automatic test_reset_midstream();
        set_req(3, 32'h0000_00FF, 32'h0000_000F, ALU_XOR);
        set_req(1, 32'h0000_00A0, 32'h0000_0005, ALU_OR);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL mid_grant3 got=%b want=1000", req_ready);
        end
        next_cycle();
        reset = 1'b1;
        req_valid = 4'b1010;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_result !== 32'hF0) begin
            failures++;
            $display("FAIL mid_in_reset got rdy=%b v=%b r=%h want rdy=0000 v=1 r=f0", req_ready, rsp_valid, rsp_result);
        end
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || dut.rr_ptr_reg !== 2'd0) begin
            failures++;
            $display("FAIL mid_after_reset got v=%b ptr=%0d want v=0 ptr=0", rsp_valid, dut.rr_ptr_reg);
        end
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL mid_first_grant got=%b want=0010", req_ready);
        end
        next_cycle();
        req_valid = 4'b1000;
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 32'hA5) begin
            failures++;
            $display("FAIL mid_rsp got v=%b id=%0d r=%h want v=1 id=1 r=a5", rsp_valid, rsp_id, rsp_result);
        end
        $display("mid: id=%0d result=%h", rsp_id, rsp_result);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        next_cycle();
        next_cycle();
    endtask

`ifdef ALU_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        set_req(2, 32'd1, 32'd1, ALU_ADD);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) next_cycle();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (grant_count[2] !== 32'd5 || grant_count[0] !== 32'd0) begin
            failures++;
            $display("FAIL stats_count got c2=%0d c0=%0d want c2=5 c0=0", grant_count[2], grant_count[0]);
        end
        next_cycle();
        do_reset();
        #1;
        checks++;
        if (grant_count[2] !== 32'd0) begin
            failures++;
            $display("FAIL stats_clear got=%0d want=0", grant_count[2]);
        end
        next_cycle();
    endtask
`endif

    initial begin
        reset = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 32'd0, 32'd0, ALU_ADD);
        #1;
        test_reset();
        test_single_add();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_reset_midstream();
`ifdef ALU_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
